// File: rtl/adrv9001_tx_serdes_framer_if.sv
// Sample/serdes-word bundle for the ADRV9001 TX serdes framer.
// ADRV9001_TX_SERDES_PRBS_EN adds the prbs_en control input.
interface adrv9001_tx_serdes_framer_if #(
    parameter int UFLOW_CNT_W = 16
);
    logic                   enable;
    logic                   strb_mode;
    logic [3:0]             phase_in;
    logic [15:0]            i_in;
    logic [15:0]            q_in;
    logic                   valid_in;
    logic                   ready_out;
    logic [15:0]            i_out;
    logic [15:0]            q_out;
    logic [15:0]            strb_out;
    logic                   valid_out;
    logic                   uflow_clr;
    logic [UFLOW_CNT_W-1:0] uflow_cnt;
`ifdef ADRV9001_TX_SERDES_PRBS_EN
    logic                   prbs_en;
`endif

    modport master (
        output enable, strb_mode, phase_in, i_in, q_in, valid_in, uflow_clr,
        input  ready_out, i_out, q_out, strb_out, valid_out, uflow_cnt
`ifdef ADRV9001_TX_SERDES_PRBS_EN
        , output prbs_en
`endif
    );

    modport slave (
        input  enable, strb_mode, phase_in, i_in, q_in, valid_in, uflow_clr,
        output ready_out, i_out, q_out, strb_out, valid_out, uflow_cnt
`ifdef ADRV9001_TX_SERDES_PRBS_EN
        , input prbs_en
`endif
    );
endinterface

// File: rtl/adrv9001_tx_serdes_framer.sv
// TX serdes framer: I/Q samples -> bit-slipped 16-bit serdes words plus strobe lane.
// Optional PRBS15 source on I/Q when ADRV9001_TX_SERDES_PRBS_EN is defined.
module adrv9001_tx_serdes_framer #(
    parameter int UFLOW_CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    adrv9001_tx_serdes_framer_if.slave    bus
);
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic                   run_s;
    logic                   start_s;
    logic                   prbs_on_s;
    logic                   ready_s;
    logic                   accept_s;
    logic                   uflow_inc_s;
    logic [15:0]            prbs_word_s;
    logic [3:0]             phase_r;
    logic                   s1_valid_r;
    logic [15:0]            cur_i_r, cur_q_r, cur_s_r;
    logic [15:0]            prev_i_r, prev_q_r, prev_s_r;
    logic [15:0]            i_out_r, q_out_r, strb_out_r;
    logic                   valid_out_r;
    logic [UFLOW_CNT_W-1:0] uflow_cnt_r;

    // Bit-slip: the upper p bits come from the previous word so the stream stays contiguous.
    function automatic logic [15:0] slip(input logic [15:0] prev, input logic [15:0] cur,
                                         input logic [3:0] p);
        logic [31:0] cat;
        cat = {prev, cur} >> p;
        return cat[15:0];
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.enable) state_nxt_s = ST_RUN;
                else            state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (bus.enable) state_nxt_s = ST_RUN;
                else            state_nxt_s = ST_IDLE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs and handshake decode
    always_comb begin
        run_s       = (state_r == ST_RUN) & bus.enable & ~rst;
        start_s     = (state_r == ST_IDLE) & bus.enable;
`ifdef ADRV9001_TX_SERDES_PRBS_EN
        prbs_on_s   = run_s & bus.prbs_en;
`else
        prbs_on_s   = 1'b0;
`endif
        ready_s     = run_s & ~prbs_on_s;
        accept_s    = ready_s & bus.valid_in;
        uflow_inc_s = run_s & ~prbs_on_s & ~accept_s;
    end

`ifdef ADRV9001_TX_SERDES_PRBS_EN
    logic [14:0] lfsr_r;
    logic [14:0] lfsr_nxt_s;

    // PRBS15 (x^15+x^14+1): 16 bits per call, first generated bit lands in the MSB.
    function automatic logic [30:0] prbs_adv(input logic [14:0] seed);
        logic [14:0] s;
        logic [15:0] w;
        logic        fb;
        s = seed;
        w = 16'h0000;
        for (int k = 0; k < 16; k++) begin
            fb = s[14] ^ s[13];
            s  = {s[13:0], fb};
            w  = {w[14:0], fb};
        end
        return {w, s};
    endfunction

    // PRBS word/next-state decode
    always_comb begin
        {prbs_word_s, lfsr_nxt_s} = prbs_adv(lfsr_r);
    end

    // LFSR state, reseeded on every IDLE->RUN start
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= 15'h7FFF;
        end else if (start_s) begin
            lfsr_r <= 15'h7FFF;
        end else if (prbs_on_s) begin
            lfsr_r <= lfsr_nxt_s;
        end else begin
            lfsr_r <= lfsr_r;
        end
    end
`else
    assign prbs_word_s = 16'h0000;
`endif

    // Phase latch, only updated on the start cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r <= 4'd0;
        end else if (start_s) begin
            phase_r <= bus.phase_in;
        end else begin
            phase_r <= phase_r;
        end
    end

    // Stage 1: capture sample (or zeros on underflow) and the strobe pattern
    always_ff @(posedge clk) begin
        if (rst || !run_s) begin
            cur_i_r    <= 16'h0000;
            cur_q_r    <= 16'h0000;
            cur_s_r    <= 16'h0000;
            s1_valid_r <= 1'b0;
        end else begin
            cur_s_r    <= bus.strb_mode ? 16'h8000 : 16'hFF00;
            s1_valid_r <= 1'b1;
            if (prbs_on_s) begin
                cur_i_r <= prbs_word_s;
                cur_q_r <= ~prbs_word_s;
            end else if (accept_s) begin
                cur_i_r <= bus.i_in;
                cur_q_r <= bus.q_in;
            end else begin
                cur_i_r <= 16'h0000;
                cur_q_r <= 16'h0000;
            end
        end
    end

    // Stage 2: bit-slip all three lanes; leaving RUN flushes everything to zero
    always_ff @(posedge clk) begin
        if (rst || !run_s) begin
            i_out_r     <= 16'h0000;
            q_out_r     <= 16'h0000;
            strb_out_r  <= 16'h0000;
            valid_out_r <= 1'b0;
            prev_i_r    <= 16'h0000;
            prev_q_r    <= 16'h0000;
            prev_s_r    <= 16'h0000;
        end else if (s1_valid_r) begin
            i_out_r     <= slip(prev_i_r, cur_i_r, phase_r);
            q_out_r     <= slip(prev_q_r, cur_q_r, phase_r);
            strb_out_r  <= slip(prev_s_r, cur_s_r, phase_r);
            valid_out_r <= 1'b1;
            prev_i_r    <= cur_i_r;
            prev_q_r    <= cur_q_r;
            prev_s_r    <= cur_s_r;
        end else begin
            i_out_r     <= 16'h0000;
            q_out_r     <= 16'h0000;
            strb_out_r  <= 16'h0000;
            valid_out_r <= 1'b0;
            prev_i_r    <= prev_i_r;
            prev_q_r    <= prev_q_r;
            prev_s_r    <= prev_s_r;
        end
    end

    // Saturating underflow counter; clear wins over increment
    always_ff @(posedge clk) begin
        if (rst || bus.uflow_clr) begin
            uflow_cnt_r <= {UFLOW_CNT_W{1'b0}};
        end else if (uflow_inc_s && !(&uflow_cnt_r)) begin
            uflow_cnt_r <= uflow_cnt_r + {{(UFLOW_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            uflow_cnt_r <= uflow_cnt_r;
        end
    end

    assign bus.ready_out = ready_s;
    assign bus.i_out     = i_out_r;
    assign bus.q_out     = q_out_r;
    assign bus.strb_out  = strb_out_r;
    assign bus.valid_out = valid_out_r;
    assign bus.uflow_cnt = uflow_cnt_r;
endmodule

// File: tb/tb_adrv9001_tx_serdes_framer.sv
// Directed bench for adrv9001_tx_serdes_framer; the PRBS scenario is built only
// when ADRV9001_TX_SERDES_PRBS_EN is defined.
module tb_adrv9001_tx_serdes_framer;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    adrv9001_tx_serdes_framer_if #(.UFLOW_CNT_W(W)) bus ();
    adrv9001_tx_serdes_framer #(.UFLOW_CNT_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leave RUN for one cycle, then start again with a new phase/mode; returns in the first RUN cycle
    task automatic restart(input logic [3:0] p, input logic m);
        bus.enable = 1'b0;
        tick();
        bus.phase_in  = p;
        bus.strb_mode = m;
        bus.enable    = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.enable = 1'b1;
        tick(); tick();
        n_checks++; if (bus.i_out !== 16'h0000) begin n_fail++; $display("FAIL rst_i: got %h exp %h", bus.i_out, 16'h0000); end
        n_checks++; if (bus.strb_out !== 16'h0000) begin n_fail++; $display("FAIL rst_strb: got %h exp %h", bus.strb_out, 16'h0000); end
        n_checks++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", bus.valid_out); end
        n_checks++; if (bus.ready_out !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b exp 0", bus.ready_out); end
        n_checks++; if (bus.uflow_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d exp 0", bus.uflow_cnt); end
    endtask

    task automatic test_basic();
        bus.i_in = 16'h1234; bus.valid_in = 1'b1; bus.phase_in = 4'd0; bus.strb_mode = 1'b0;
        rst = 1'b0;
        tick();
        n_checks++; if (bus.ready_out !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b exp 1", bus.ready_out); end
        tick();
        bus.i_in = 16'h5678;
        n_checks++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL basic_lat_valid: got %b exp 0", bus.valid_out); end
        tick();
        n_checks++; if (bus.i_out !== 16'h1234) begin n_fail++; $display("FAIL basic_i0: got %h exp %h", bus.i_out, 16'h1234); end
        n_checks++; if (bus.strb_out !== 16'hFF00) begin n_fail++; $display("FAIL basic_strb: got %h exp %h", bus.strb_out, 16'hFF00); end
        n_checks++; if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b exp 1", bus.valid_out); end
        tick();
        n_checks++; if (bus.i_out !== 16'h5678) begin n_fail++; $display("FAIL basic_i1: got %h exp %h", bus.i_out, 16'h5678); end
    endtask

    task automatic test_phase4();
        bus.i_in = 16'hABCD; bus.q_in = 16'hF0F0;
        restart(4'd4, 1'b0);
        tick();
        bus.i_in = 16'h1234;
        tick();
        n_checks++; if (bus.i_out !== 16'h0ABC) begin n_fail++; $display("FAIL ph4_i0: got %h exp %h", bus.i_out, 16'h0ABC); end
        n_checks++; if (bus.q_out !== 16'h0F0F) begin n_fail++; $display("FAIL ph4_q0: got %h exp %h", bus.q_out, 16'h0F0F); end
        n_checks++; if (bus.strb_out !== 16'h0FF0) begin n_fail++; $display("FAIL ph4_s0: got %h exp %h", bus.strb_out, 16'h0FF0); end
        tick();
        n_checks++; if (bus.i_out !== 16'hD123) begin n_fail++; $display("FAIL ph4_i1: got %h exp %h", bus.i_out, 16'hD123); end
        n_checks++; if (bus.strb_out !== 16'h0FF0) begin n_fail++; $display("FAIL ph4_s1: got %h exp %h", bus.strb_out, 16'h0FF0); end
    endtask

    task automatic test_strobe();
        bus.i_in = 16'h8001;
        restart(4'd15, 1'b0);
        repeat (4) tick();
        n_checks++; if (bus.strb_out !== 16'hFE01) begin n_fail++; $display("FAIL strb_m0: got %h exp %h", bus.strb_out, 16'hFE01); end
        n_checks++; if (bus.i_out !== 16'h0003) begin n_fail++; $display("FAIL strb_i: got %h exp %h", bus.i_out, 16'h0003); end
        bus.strb_mode = 1'b1;
        tick(); tick();
        n_checks++; if (bus.strb_out !== 16'hFE01) begin n_fail++; $display("FAIL strb_edge: got %h exp %h", bus.strb_out, 16'hFE01); end
        tick();
        n_checks++; if (bus.strb_out !== 16'h0001) begin n_fail++; $display("FAIL strb_m1a: got %h exp %h", bus.strb_out, 16'h0001); end
        tick();
        n_checks++; if (bus.strb_out !== 16'h0001) begin n_fail++; $display("FAIL strb_m1b: got %h exp %h", bus.strb_out, 16'h0001); end
    endtask

    task automatic test_underflow();
        bus.i_in = 16'h1111; bus.valid_in = 1'b1;
        restart(4'd0, 1'b0);
        repeat (3) tick();
        bus.uflow_clr = 1'b1;
        tick();
        bus.uflow_clr = 1'b0;
        n_checks++; if (bus.uflow_cnt !== 4'd0) begin n_fail++; $display("FAIL uf_clr0: got %0d exp 0", bus.uflow_cnt); end
        bus.valid_in = 1'b0;
        repeat (3) tick();
        bus.valid_in = 1'b1; bus.i_in = 16'h2222;
        n_checks++; if (bus.uflow_cnt !== 4'd3) begin n_fail++; $display("FAIL uf_cnt3: got %0d exp 3", bus.uflow_cnt); end
        n_checks++; if (bus.i_out !== 16'h0000) begin n_fail++; $display("FAIL uf_i0: got %h exp %h", bus.i_out, 16'h0000); end
        n_checks++; if (bus.q_out !== 16'h0000) begin n_fail++; $display("FAIL uf_q0: got %h exp %h", bus.q_out, 16'h0000); end
        n_checks++; if (bus.strb_out !== 16'hFF00) begin n_fail++; $display("FAIL uf_strb: got %h exp %h", bus.strb_out, 16'hFF00); end
        tick();
        n_checks++; if (bus.i_out !== 16'h0000) begin n_fail++; $display("FAIL uf_i2: got %h exp %h", bus.i_out, 16'h0000); end
        tick();
        n_checks++; if (bus.i_out !== 16'h2222) begin n_fail++; $display("FAIL uf_resume: got %h exp %h", bus.i_out, 16'h2222); end
        bus.valid_in = 1'b0;
        repeat (20) tick();
        n_checks++; if (bus.uflow_cnt !== 4'd15) begin n_fail++; $display("FAIL uf_sat: got %0d exp 15", bus.uflow_cnt); end
        bus.uflow_clr = 1'b1;
        tick();
        bus.uflow_clr = 1'b0;
        n_checks++; if (bus.uflow_cnt !== 4'd0) begin n_fail++; $display("FAIL uf_clr_wins: got %0d exp 0", bus.uflow_cnt); end
        tick();
        n_checks++; if (bus.uflow_cnt !== 4'd1) begin n_fail++; $display("FAIL uf_after_clr: got %0d exp 1", bus.uflow_cnt); end
        bus.valid_in = 1'b1;
    endtask

    task automatic test_rst_and_phase();
        bus.i_in = 16'h1234; bus.valid_in = 1'b1;
        restart(4'd0, 1'b0);
        repeat (3) tick();
        n_checks++; if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL mid_valid: got %b exp 1", bus.valid_out); end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.ready_out !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b exp 0", bus.ready_out); end
        tick();
        n_checks++; if (bus.i_out !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_i: got %h exp %h", bus.i_out, 16'h0000); end
        n_checks++; if (bus.strb_out !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_strb: got %h exp %h", bus.strb_out, 16'h0000); end
        n_checks++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b exp 0", bus.valid_out); end
        rst = 1'b0;
        tick();
        bus.phase_in = 4'd8;
        repeat (4) tick();
        n_checks++; if (bus.i_out !== 16'h1234) begin n_fail++; $display("FAIL ph_ignored: got %h exp %h", bus.i_out, 16'h1234); end
        bus.enable = 1'b0;
        tick();
        n_checks++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL dis_valid: got %b exp 0", bus.valid_out); end
        n_checks++; if (bus.ready_out !== 1'b0) begin n_fail++; $display("FAIL dis_ready: got %b exp 0", bus.ready_out); end
        bus.enable = 1'b1;
        tick(); tick(); tick();
        n_checks++; if (bus.i_out !== 16'h0012) begin n_fail++; $display("FAIL relatch_first: got %h exp %h", bus.i_out, 16'h0012); end
        tick();
        n_checks++; if (bus.i_out !== 16'h3412) begin n_fail++; $display("FAIL relatch_steady: got %h exp %h", bus.i_out, 16'h3412); end
    endtask

`ifdef ADRV9001_TX_SERDES_PRBS_EN
    task automatic test_prbs();
        logic [14:0]            r;
        logic [15:0]            w;
        logic                   fb;
        logic [W-1:0]           cnt0;
        cnt0 = bus.uflow_cnt;
        bus.prbs_en  = 1'b1;
        bus.valid_in = 1'b0;
        restart(4'd0, 1'b0);
        n_checks++; if (bus.ready_out !== 1'b0) begin n_fail++; $display("FAIL prbs_ready: got %b exp 0", bus.ready_out); end
        tick(); tick();
        r = 15'h7FFF;
        for (int n = 0; n < 4; n++) begin
            w = 16'h0000;
            for (int b = 0; b < 16; b++) begin
                fb = r[14] ^ r[13];
                r  = {r[13:0], fb};
                w  = {w[14:0], fb};
            end
            n_checks++; if (bus.i_out !== w) begin n_fail++; $display("FAIL prbs_i%0d: got %h exp %h", n, bus.i_out, w); end
            n_checks++; if (bus.q_out !== ~w) begin n_fail++; $display("FAIL prbs_q%0d: got %h exp %h", n, bus.q_out, ~w); end
            tick();
        end
        n_checks++; if (bus.uflow_cnt !== cnt0) begin n_fail++; $display("FAIL prbs_cnt: got %0d exp %0d", bus.uflow_cnt, cnt0); end
        bus.prbs_en  = 1'b0;
        bus.valid_in = 1'b1;
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.enable = 1'b0; bus.strb_mode = 1'b0; bus.phase_in = 4'd0;
        bus.i_in = 16'h0000; bus.q_in = 16'h0000; bus.valid_in = 1'b0; bus.uflow_clr = 1'b0;
`ifdef ADRV9001_TX_SERDES_PRBS_EN
        bus.prbs_en = 1'b0;
`endif
        test_reset();
        test_basic();
        test_phase4();
        test_strobe();
        test_underflow();
        test_rst_and_phase();
`ifdef ADRV9001_TX_SERDES_PRBS_EN
        test_prbs();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
